// File: rtl/bbpd_vote.sv
// -----------------------------------------------------------------------------
// bbpd_vote -- bang-bang (Alexander) phase detector with vote decimation.
//
// Each counted sample pair is classified from the previous center sample,
// the current center sample and the edge sample taken between them:
//   no data transition         -> no vote
//   edge matches current data  -> clock late  (+1)
//   edge matches previous data -> clock early (-1)
// Votes are summed over a window of 2**WIN_LOG2 counted samples. One cycle
// after the closing sample, win_done pulses, and at most one of up/dn
// pulses if the final vote magnitude exceeds THRESH. This limits the loop
// filter to a single update per window.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   enable      detector enable; low clears the window and forces re-priming
//   samp_valid  a new center/edge sample pair is present
//   data_samp   center sample of the current bit
//   edge_samp   edge sample between the previous and the current bit
//   up          one-cycle pulse: clock late, speed up
//   dn          one-cycle pulse: clock early, slow down
//   vote        signed running vote of the current window
//   win_done    one-cycle pulse marking the end of each window
// -----------------------------------------------------------------------------
module bbpd_vote #(
    parameter int WIN_LOG2 = 3,
    parameter int THRESH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                samp_valid,
    input  logic                data_samp,
    input  logic                edge_samp,
    output logic                up,
    output logic                dn,
    output logic [WIN_LOG2+1:0] vote,
    output logic                win_done
);

    // Full-window vote spans +/-2**WIN_LOG2, which needs WIN_LOG2+2 signed bits.
    localparam int VW = WIN_LOG2 + 2;

    localparam logic signed [VW-1:0] THR_POS = VW'(THRESH);
    localparam logic signed [VW-1:0] THR_NEG = -THR_POS;

    logic signed [VW-1:0]   vote_r;
    logic signed [VW-1:0]   step;
    logic signed [VW-1:0]   vote_next;
    logic [WIN_LOG2-1:0]    cnt;
    logic                   d_prev;
    logic                   have_prev;
    logic                   counted;
    logic                   closing;

    assign counted = enable && samp_valid && have_prev;
    assign closing = counted && (cnt == '1);

    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        step = '0;
        if (d_prev != data_samp) begin
            // With one-bit samples a transition means the edge sample equals
            // exactly one of the two neighbouring data samples.
            step = (edge_samp == data_samp) ? VW'(1) : VW'(-1);
        end
        vote_next = vote_r + step;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_r    <= '0;
            cnt       <= '0;
            d_prev    <= 1'b0;
            have_prev <= 1'b0;
            up        <= 1'b0;
            dn        <= 1'b0;
            win_done  <= 1'b0;
        end else begin
            // Pulses last one cycle unless a window closes on this edge.
            up       <= 1'b0;
            dn       <= 1'b0;
            win_done <= 1'b0;

            if (!enable) begin
                vote_r    <= '0;
                cnt       <= '0;
                have_prev <= 1'b0;
            end else if (samp_valid) begin
                d_prev <= data_samp;
                if (!have_prev) begin
                    // Priming sample: establishes d_prev only.
                    have_prev <= 1'b1;
                end else if (closing) begin
                    // The closing sample's own vote is part of the decision;
                    // the new window starts immediately with no dead cycle.
                    win_done <= 1'b1;
                    up       <= (vote_next > THR_POS);
                    dn       <= (vote_next < THR_NEG);
                    vote_r   <= '0;
                    cnt      <= '0;
                end else begin
                    vote_r <= vote_next;
                    cnt    <= cnt + WIN_LOG2'(1);
                end
            end
        end
    end

    assign vote = vote_r;

endmodule
